// File: rtl/bus_arb5.sv
// Five-requester round-robin bus arbiter with burst hold, owner-only acks,
// a mandatory idle bubble between grants and a stall timeout.
module bus_arb5 #(
   parameter int MAX_HOLD = 255,
   parameter int HOLD_W   = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] req,
   input  logic [4:0] last,
   input  logic       dn_ready,
   output logic [4:0] sel,
   output logic       dn_valid,
   output logic [4:0] ack,
   output logic       busy,
   output logic       timeout
);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t            state, state_n;
   logic [2:0]        ptr, ptr_n;
   logic [2:0]        owner, pick, rel_ptr;
   logic [HOLD_W-1:0] cnt, cnt_n;
   logic [4:0]        sel_n;
   logic              timeout_n;
   logic              found;
   logic              accept;

   assign dn_valid = busy & |(req & sel);
   assign accept   = dn_valid & dn_ready;
   assign ack      = sel & {5{accept}};

   always_comb begin
      owner = '0;
      for (int unsigned i = 0; i < 5; i++) begin
         if (sel[i]) owner = 3'(i);
      end
   end

   assign rel_ptr = (owner == 3'd4) ? 3'd0 : owner + 3'd1;

   // Round-robin search starting at ptr, wrapping 4 -> 0.
   always_comb begin
      pick  = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < 5; i++) begin
         logic [3:0] idx;
         idx = 4'(ptr) + 4'(i);
         if (idx >= 4'd5) idx = idx - 4'd5;
         if (!found && req[idx[2:0]]) begin
            found = 1'b1;
            pick  = idx[2:0];
         end
      end
   end

   always_comb begin
      state_n   = state;
      sel_n     = sel;
      ptr_n     = ptr;
      cnt_n     = cnt;
      timeout_n = 1'b0;
      case (state)
         IDLE: begin
            if (found) begin
               sel_n   = 5'b00001 << pick;
               cnt_n   = '0;
               state_n = GRANT;
            end
         end
         GRANT: begin
            if (accept) begin
               cnt_n = '0;
               if (|(last & sel)) begin
                  state_n = IDLE;
                  sel_n   = '0;
                  ptr_n   = rel_ptr;
               end
            end else if (cnt == HOLD_W'(MAX_HOLD)) begin
               state_n   = IDLE;
               sel_n     = '0;
               ptr_n     = rel_ptr;
               timeout_n = 1'b1;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         sel     <= '0;
         ptr     <= '0;
         cnt     <= '0;
         busy    <= 1'b0;
         timeout <= 1'b0;
      end else begin
         state   <= state_n;
         sel     <= sel_n;
         ptr     <= ptr_n;
         cnt     <= cnt_n;
         busy    <= (state_n == GRANT);
         timeout <= timeout_n;
      end
   end

endmodule

// File: tb/tb_bus_arb5.sv
// Directed self-checking bench for bus_arb5 (MAX_HOLD reduced to 4).
module tb_bus_arb5;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] req, last;
   logic       dn_ready;
   logic [4:0] sel, ack;
   logic       dn_valid, busy, timeout;

   int compared = 0;
   int mismatched = 0;

   bus_arb5 #(.MAX_HOLD(4), .HOLD_W(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .last     (last),
      .dn_ready (dn_ready),
      .sel      (sel),
      .dn_valid (dn_valid),
      .ack      (ack),
      .busy     (busy),
      .timeout  (timeout)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req = '0; last = '0; dn_ready = 1'b0;
      #12;
      compared++; if (sel !== 5'b0)   begin mismatched++; $display("FAIL reset_sel got %b want %b", sel, 5'b0); end
      compared++; if (busy !== 1'b0)  begin mismatched++; $display("FAIL reset_busy got %b want 0", busy); end
      compared++; if (timeout !== 1'b0) begin mismatched++; $display("FAIL reset_timeout got %b want 0", timeout); end
      compared++; if (dn_valid !== 1'b0) begin mismatched++; $display("FAIL reset_dn_valid got %b want 0", dn_valid); end
      compared++; if (ack !== 5'b0)   begin mismatched++; $display("FAIL reset_ack got %b want %b", ack, 5'b0); end
      step();
      rst_n = 1'b1;
      step();
      compared++; if (sel !== 5'b0)   begin mismatched++; $display("FAIL idle_noreq_sel got %b want %b", sel, 5'b0); end
   endtask

   task automatic test_rotation();
      req = 5'b10100; last = '0; dn_ready = 1'b0;
      step();
      compared++; if (sel !== 5'b00100) begin mismatched++; $display("FAIL rot_sel got %b want %b", sel, 5'b00100); end
      compared++; if (busy !== 1'b1)    begin mismatched++; $display("FAIL rot_busy got %b want 1", busy); end
      compared++; if (dn_valid !== 1'b1) begin mismatched++; $display("FAIL rot_dn_valid got %b want 1", dn_valid); end
      compared++; if (ack !== 5'b0)     begin mismatched++; $display("FAIL rot_ack_noready got %b want %b", ack, 5'b0); end
      dn_ready = 1'b1; last = 5'b00100;
      #1;
      compared++; if (ack !== 5'b00100) begin mismatched++; $display("FAIL rot_ack got %b want %b", ack, 5'b00100); end
      step();
      dn_ready = 1'b0; last = '0;
      #1;
      compared++; if (sel !== 5'b0)     begin mismatched++; $display("FAIL rot_bubble_sel got %b want %b", sel, 5'b0); end
      compared++; if (busy !== 1'b0)    begin mismatched++; $display("FAIL rot_bubble_busy got %b want 0", busy); end
      compared++; if (ack !== 5'b0)     begin mismatched++; $display("FAIL rot_bubble_ack got %b want %b", ack, 5'b0); end
      step();
      compared++; if (sel !== 5'b10000) begin mismatched++; $display("FAIL rot_next_sel got %b want %b", sel, 5'b10000); end
   endtask

   task automatic test_wrap();
      dn_ready = 1'b1; last = 5'b10000;
      #1;
      compared++; if (ack !== 5'b10000) begin mismatched++; $display("FAIL wrap_ack got %b want %b", ack, 5'b10000); end
      step();
      req = 5'b00011; dn_ready = 1'b0; last = '0;
      #1;
      compared++; if (sel !== 5'b0)     begin mismatched++; $display("FAIL wrap_bubble_sel got %b want %b", sel, 5'b0); end
      step();
      compared++; if (sel !== 5'b00001) begin mismatched++; $display("FAIL wrap_sel got %b want %b", sel, 5'b00001); end
      dn_ready = 1'b1; last = 5'b00001;
      step();
      dn_ready = 1'b0; last = '0; req = '0;
      #1;
      compared++; if (sel !== 5'b0)     begin mismatched++; $display("FAIL wrap_release_sel got %b want %b", sel, 5'b0); end
   endtask

   task automatic test_burst();
      logic [4:0] rdy_pat;
      int acks;
      rdy_pat = 5'b10101;
      acks = 0;
      req = 5'b00010;
      step();
      for (int k = 0; k < 5; k++) begin
         dn_ready = rdy_pat[k];
         last = (k == 4) ? 5'b00010 : 5'b00000;
         #1;
         compared++; if (sel !== 5'b00010) begin mismatched++; $display("FAIL burst_sel[%0d] got %b want %b", k, sel, 5'b00010); end
         if (ack == 5'b00010) acks++;
         step();
      end
      dn_ready = 1'b0; last = '0; req = '0;
      #1;
      compared++; if (acks !== 3)       begin mismatched++; $display("FAIL burst_ack_count got %0d want 3", acks); end
      compared++; if (sel !== 5'b0)     begin mismatched++; $display("FAIL burst_release_sel got %b want %b", sel, 5'b0); end
      step();
   endtask

   task automatic test_owner_drop();
      req = 5'b01000;
      step();
      compared++; if (sel !== 5'b01000) begin mismatched++; $display("FAIL drop_sel got %b want %b", sel, 5'b01000); end
      dn_ready = 1'b1;
      #1;
      compared++; if (ack !== 5'b01000) begin mismatched++; $display("FAIL drop_first_ack got %b want %b", ack, 5'b01000); end
      step();
      for (int k = 0; k < 2; k++) begin
         req = 5'b00001; last = 5'b00001;
         #1;
         compared++; if (dn_valid !== 1'b0) begin mismatched++; $display("FAIL drop_dn_valid[%0d] got %b want 0", k, dn_valid); end
         compared++; if (ack !== 5'b0)      begin mismatched++; $display("FAIL drop_ack[%0d] got %b want %b", k, ack, 5'b0); end
         compared++; if (sel !== 5'b01000)  begin mismatched++; $display("FAIL drop_hold_sel[%0d] got %b want %b", k, sel, 5'b01000); end
         step();
      end
      req = 5'b01000; last = 5'b01000;
      #1;
      compared++; if (ack !== 5'b01000) begin mismatched++; $display("FAIL drop_last_ack got %b want %b", ack, 5'b01000); end
      step();
      req = '0; last = '0; dn_ready = 1'b0;
      #1;
      compared++; if (sel !== 5'b0)     begin mismatched++; $display("FAIL drop_release_sel got %b want %b", sel, 5'b0); end
   endtask

   task automatic test_timeout();
      req = 5'b00001; dn_ready = 1'b0;
      step();
      for (int k = 0; k < 5; k++) begin
         compared++; if (sel !== 5'b00001) begin mismatched++; $display("FAIL to_hold_sel[%0d] got %b want %b", k, sel, 5'b00001); end
         compared++; if (timeout !== 1'b0) begin mismatched++; $display("FAIL to_early_pulse[%0d] got %b want 0", k, timeout); end
         step();
      end
      req = 5'b00011;
      #1;
      compared++; if (sel !== 5'b0)     begin mismatched++; $display("FAIL to_release_sel got %b want %b", sel, 5'b0); end
      compared++; if (timeout !== 1'b1) begin mismatched++; $display("FAIL to_pulse got %b want 1", timeout); end
      step();
      compared++; if (timeout !== 1'b0) begin mismatched++; $display("FAIL to_pulse_width got %b want 0", timeout); end
      compared++; if (sel !== 5'b00010) begin mismatched++; $display("FAIL to_next_sel got %b want %b", sel, 5'b00010); end
   endtask

   task automatic test_async_reset();
      dn_ready = 1'b1; last = '0;
      #1;
      compared++; if (ack !== 5'b00010) begin mismatched++; $display("FAIL ar_pre_ack got %b want %b", ack, 5'b00010); end
      #1;
      rst_n = 1'b0;
      #1;
      compared++; if (sel !== 5'b0)     begin mismatched++; $display("FAIL ar_sel got %b want %b", sel, 5'b0); end
      compared++; if (ack !== 5'b0)     begin mismatched++; $display("FAIL ar_ack got %b want %b", ack, 5'b0); end
      compared++; if (busy !== 1'b0)    begin mismatched++; $display("FAIL ar_busy got %b want 0", busy); end
      req = 5'b11111; dn_ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      step();
      compared++; if (sel !== 5'b00001) begin mismatched++; $display("FAIL ar_resume_sel got %b want %b", sel, 5'b00001); end
   endtask

   initial begin
      test_reset();
      test_rotation();
      test_wrap();
      test_burst();
      test_owner_drop();
      test_timeout();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
